// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: shadows ID/EX, issues predictor updates and flushes.
// Optional statistics counters are enabled by defining BRU_STATS_EN.
module branch_resolve_unit (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_IF_valid,
  input  logic [21:0] i_IF_pc,
  input  logic        i_IF_taken,
  input  logic        i_Stall,
  input  logic        i_EX_isbranch,
  input  logic        i_EX_outcome,
  input  logic [21:0] i_EX_target,
  output logic [21:0] o_ALU_pc,
  output logic        o_ALU_isbranch,
  output logic        o_ALU_outcome,
  output logic        o_ALU_prediction,
  output logic        o_flush,
  output logic [21:0] o_redirect_pc,
  output logic [15:0] o_branch_count,
  output logic [15:0] o_mispredict_count
);

  typedef struct packed {
    logic        valid;
    logic [21:0] pc;
    logic        pred;
  } stage_t;

  stage_t      id_q;
  stage_t      ex_q;
  logic        eval;
  logic        mispredict;
  logic [21:0] redirect_nxt;

  assign eval       = ~i_Stall & ex_q.valid & i_EX_isbranch;
  assign mispredict = eval & (ex_q.pred != i_EX_outcome);

  // Fall-through wraps naturally at the 22-bit boundary
  assign redirect_nxt = i_EX_outcome ? i_EX_target
                                     : ex_q.pc + 22'd1;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      id_q             <= '0;
      ex_q             <= '0;
      o_ALU_pc         <= '0;
      o_ALU_isbranch   <= 1'b0;
      o_ALU_outcome    <= 1'b0;
      o_ALU_prediction <= 1'b0;
      o_flush          <= 1'b0;
      o_redirect_pc    <= '0;
    end else begin
      o_ALU_isbranch <= eval;
      o_flush        <= mispredict;
      if (eval) begin
        o_ALU_pc         <= ex_q.pc;
        o_ALU_outcome    <= i_EX_outcome;
        o_ALU_prediction <= ex_q.pred;
      end
      if (mispredict)
        o_redirect_pc <= redirect_nxt;
      if (!i_Stall) begin
        if (mispredict) begin
          id_q.valid <= 1'b0;
          ex_q.valid <= 1'b0;
        end else begin
          id_q.valid <= i_IF_valid & ~o_flush;
          id_q.pc    <= i_IF_pc;
          id_q.pred  <= i_IF_taken;
          ex_q       <= id_q;
        end
      end
    end
  end

`ifdef BRU_STATS_EN
  logic [15:0] bcnt_q;
  logic [15:0] mcnt_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (eval && bcnt_q != 16'hFFFF)
        bcnt_q <= bcnt_q + 16'd1;
      if (mispredict && mcnt_q != 16'hFFFF)
        mcnt_q <= mcnt_q + 16'd1;
    end
  end

  assign o_branch_count     = bcnt_q;
  assign o_mispredict_count = mcnt_q;
`else
  assign o_branch_count     = 16'h0;
  assign o_mispredict_count = 16'h0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit.
// Expected updates are queued at drive time and popped when due.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [21:0] if_pc;
  logic        if_taken;
  logic        stall;
  logic        is_br;
  logic        outcome;
  logic [21:0] target;
  logic [21:0] alu_pc;
  logic        alu_isb;
  logic        alu_outc;
  logic        alu_pred;
  logic        flush;
  logic [21:0] redir;
  logic [15:0] bcnt;
  logic [15:0] mcnt;

  branch_resolve_unit dut (
    .i_Clk              (clk),
    .i_Reset            (rst),
    .i_IF_valid         (if_valid),
    .i_IF_pc            (if_pc),
    .i_IF_taken         (if_taken),
    .i_Stall            (stall),
    .i_EX_isbranch      (is_br),
    .i_EX_outcome       (outcome),
    .i_EX_target        (target),
    .o_ALU_pc           (alu_pc),
    .o_ALU_isbranch     (alu_isb),
    .o_ALU_outcome      (alu_outc),
    .o_ALU_prediction   (alu_pred),
    .o_flush            (flush),
    .o_redirect_pc      (redir),
    .o_branch_count     (bcnt),
    .o_mispredict_count (mcnt)
  );

  typedef struct {
    int          due;
    logic [21:0] pc;
    logic        outc;
    logic        pred;
    logic        flush;
    logic [21:0] redir;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errs = 0;
  int          cyc = 0;
  bit          rst_seen = 0;
  bit          started = 0;
  logic [21:0] exp_redir = '0;
  int          exp_b = 0;
  int          exp_m = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_seen = rst;
  end

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (rst_seen) exp_redir = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("upd_strobe", 32'(alu_isb), 32'd1);
        check("upd_pc", 32'(alu_pc), 32'(e.pc));
        check("upd_outcome", 32'(alu_outc), 32'(e.outc));
        check("upd_pred", 32'(alu_pred), 32'(e.pred));
        check("flush", 32'(flush), 32'(e.flush));
        if (e.flush) begin
          check("redirect", 32'(redir), 32'(e.redir));
          exp_redir = e.redir;
        end else begin
          check("redir_hold", 32'(redir), 32'(exp_redir));
        end
      end else begin
        check("idle_strobe", 32'(alu_isb), 32'd0);
        check("idle_flush", 32'(flush), 32'd0);
        check("redir_hold", 32'(redir), 32'(exp_redir));
      end
    end
  end

  task automatic push(input logic [21:0] pc,
                      input logic pred,
                      input logic outc,
                      input logic [21:0] tgt);
    exp_t e;
    e.due   = cyc + 1;
    e.pc    = pc;
    e.outc  = outc;
    e.pred  = pred;
    e.flush = (pred != outc);
    e.redir = outc ? tgt : pc + 22'd1;
    sb.push_back(e);
    exp_b++;
    if (e.flush) exp_m++;
  endtask

  task automatic branch(input logic [21:0] pc,
                        input logic pred,
                        input logic outc,
                        input logic [21:0] tgt,
                        input int stall_n,
                        input bit wrong);
    @(negedge clk);
    if_valid = 1'b1;
    if_pc    = pc;
    if_taken = pred;
    is_br    = 1'b0;
    @(negedge clk);
    if_valid = 1'b0;
    @(negedge clk);
    is_br   = 1'b1;
    outcome = outc;
    target  = tgt;
    stall   = (stall_n > 0);
    repeat (stall_n) @(negedge clk);
    stall = 1'b0;
    if (wrong) begin
      if_valid = 1'b1;
      if_pc    = pc + 22'd5;
      if_taken = ~outc;
    end
    push(pc, pred, outc, tgt);
    @(negedge clk);
    is_br = wrong;
    @(negedge clk);
    if_valid = 1'b0;
    @(negedge clk);
    is_br = 1'b0;
  endtask

  task automatic back_to_back(input logic [21:0] a);
    @(negedge clk);
    if_valid = 1'b1;
    if_pc    = a;
    if_taken = 1'b1;
    @(negedge clk);
    if_pc    = a + 22'd1;
    if_taken = 1'b0;
    @(negedge clk);
    if_pc    = a + 22'd2;
    if_taken = 1'b1;
    is_br    = 1'b1;
    outcome  = 1'b1;
    push(a, 1'b1, 1'b1, 22'h0);
    @(negedge clk);
    if_valid = 1'b0;
    outcome  = 1'b0;
    push(a + 22'd1, 1'b0, 1'b0, 22'h0);
    @(negedge clk);
    outcome = 1'b1;
    push(a + 22'd2, 1'b1, 1'b1, 22'h0);
    @(negedge clk);
    is_br = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pc"}, 32'(alu_pc), 32'd0);
    check({tag, "_strobe"}, 32'(alu_isb), 32'd0);
    check({tag, "_outc"}, 32'(alu_outc), 32'd0);
    check({tag, "_pred"}, 32'(alu_pred), 32'd0);
    check({tag, "_flush"}, 32'(flush), 32'd0);
    check({tag, "_redir"}, 32'(redir), 32'd0);
    check({tag, "_bcnt"}, 32'(bcnt), 32'd0);
    check({tag, "_mcnt"}, 32'(mcnt), 32'd0);
  endtask

  task automatic check_counts(input string tag);
`ifdef BRU_STATS_EN
    check({tag, "_bcnt"}, 32'(bcnt), 32'(exp_b));
    check({tag, "_mcnt"}, 32'(mcnt), 32'(exp_m));
`else
    check({tag, "_bcnt"}, 32'(bcnt), 32'd0);
    check({tag, "_mcnt"}, 32'(mcnt), 32'd0);
`endif
  endtask

  initial begin
    rst      = 1'b1;
    if_valid = 1'b0;
    if_pc    = '0;
    if_taken = 1'b0;
    stall    = 1'b0;
    is_br    = 1'b0;
    outcome  = 1'b0;
    target   = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst     = 1'b0;
    started = 1'b1;

    branch(22'h000010, 1'b1, 1'b1, 22'h000000, 0, 1'b0);
    branch(22'h000020, 1'b1, 1'b0, 22'h000055, 0, 1'b1);
    branch(22'h3FFFFF, 1'b1, 1'b0, 22'h000077, 0, 1'b0);
    branch(22'h000040, 1'b0, 1'b1, 22'h000100, 0, 1'b0);
    branch(22'h000080, 1'b0, 1'b1, 22'h000200, 3, 1'b0);
    branch(22'h000090, 1'b1, 1'b0, 22'h000300, 2, 1'b1);
    back_to_back(22'h0000A0);
    repeat (2) @(negedge clk);
    check_counts("mix");

    // mispredict evaluation collides with reset
    @(negedge clk);
    if_valid = 1'b1;
    if_pc    = 22'h000123;
    if_taken = 1'b1;
    @(negedge clk);
    if_valid = 1'b0;
    @(negedge clk);
    is_br   = 1'b1;
    outcome = 1'b0;
    rst     = 1'b1;
    exp_b   = 0;
    exp_m   = 0;
    @(negedge clk);
    rst   = 1'b0;
    check_zero("rst_abort");
    @(negedge clk);
    is_br = 1'b0;

    branch(22'h000100, 1'b1, 1'b1, 22'h000000, 0, 1'b0);
    branch(22'h000101, 1'b0, 1'b0, 22'h000000, 0, 1'b0);
    branch(22'h000102, 1'b1, 1'b0, 22'h000000, 0, 1'b1);
    branch(22'h000103, 1'b0, 1'b1, 22'h000300, 1, 1'b0);
    branch(22'h000104, 1'b1, 1'b1, 22'h000000, 0, 1'b0);
    repeat (3) @(negedge clk);
    check_counts("stats");
    check("drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
